// File: rtl/cond_status_unit.sv
// NZCV status register with masked writeback, shadow-SR stack and
// NUM_CH condition-code evaluators with an optional output register.
module cond_status_unit #(
    parameter int         NUM_CH    = 2,
    parameter int         STK_DEPTH = 4,
    parameter int         OUT_REG   = 1,
    parameter int         BYPASS    = 1,
    parameter logic [3:0] RESET_SR  = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sr_we,
    input  logic [3:0]            sr_mask,
    input  logic [3:0]            sr_in,
    output logic [3:0]            sr_out,
    input  logic                  push,
    input  logic                  pop,
    output logic                  stk_full,
    output logic                  stk_empty,
    output logic                  stk_err,
    input  logic [NUM_CH-1:0]     cond_valid,
    input  logic [4*NUM_CH-1:0]   cond,
    input  logic                  stall,
    input  logic                  flush,
    output logic [NUM_CH-1:0]     pass_valid,
    output logic [NUM_CH-1:0]     cond_pass
);

    localparam int AW = $clog2(STK_DEPTH);
    localparam int PW = AW + 1;

    logic [3:0]    sr_q, sr_d;
    logic [PW-1:0] sp_q, sp_d;
    logic [3:0]    stk_q [STK_DEPTH];
    logic [3:0]    stk_d [STK_DEPTH];
    logic          stk_err_q, stk_err_d;
    logic          push_ok, pop_ok;
    logic [AW-1:0] top_idx, wr_idx;
    logic [3:0]    sr_wr, flags;
    logic [NUM_CH-1:0] lane_pv, lane_cp;

    assign stk_full  = (sp_q == PW'(STK_DEPTH));
    assign stk_empty = (sp_q == '0);
    assign top_idx   = AW'(sp_q - PW'(1));
    assign wr_idx    = sp_q[AW-1:0];
    assign sr_out    = sr_q;
    assign stk_err   = stk_err_q;

    always_comb begin
        push_ok   = push & ~pop & ~stk_full;
        pop_ok    = pop & ~push & ~stk_empty;
        stk_err_d = (push & pop) | (push & stk_full) | (pop & stk_empty);
        sr_wr     = (sr_in & sr_mask) | (sr_q & ~sr_mask);
        sr_d      = sr_q;
        sp_d      = sp_q;
        stk_d     = stk_q;
        // A legal pop owns the SR this cycle; writeback is dropped.
        if (pop_ok) begin
            sr_d = stk_q[top_idx];
            sp_d = sp_q - PW'(1);
        end else if (sr_we) begin
            sr_d = sr_wr;
        end
        if (push_ok) begin
            stk_d[wr_idx] = sr_q;
            sp_d          = sp_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= RESET_SR;
            sp_q      <= '0;
            stk_err_q <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            sr_q      <= sr_d;
            sp_q      <= sp_d;
            stk_err_q <= stk_err_d;
            stk_q     <= stk_d;
        end
    end

    function automatic logic eval_cc(input logic [3:0] cc,
                                     input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:    eval_cc = z;
            4'd1:    eval_cc = ~z;
            4'd2:    eval_cc = c;
            4'd3:    eval_cc = ~c;
            4'd4:    eval_cc = n;
            4'd5:    eval_cc = ~n;
            4'd6:    eval_cc = v;
            4'd7:    eval_cc = ~v;
            4'd8:    eval_cc = c & ~z;
            4'd9:    eval_cc = ~c | z;
            4'd10:   eval_cc = (n == v);
            4'd11:   eval_cc = (n != v);
            4'd12:   eval_cc = ~z & (n == v);
            4'd13:   eval_cc = z | (n != v);
            4'd14:   eval_cc = 1'b1;
            default: eval_cc = 1'b0;
        endcase
    endfunction

    assign flags = (BYPASS != 0) ? sr_d : sr_q;

    always_comb begin
        lane_pv = '0;
        lane_cp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane_pv[i] = cond_valid[i];
            lane_cp[i] = cond_valid[i] & eval_cc(cond[4*i +: 4], flags);
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic [NUM_CH-1:0] pv_q, pv_d, cp_q, cp_d;

        always_comb begin
            pv_d = pv_q;
            cp_d = cp_q;
            if (flush) begin
                pv_d = '0;
                cp_d = '0;
            end else if (!stall) begin
                pv_d = lane_pv;
                cp_d = lane_cp;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv_q <= '0;
                cp_q <= '0;
            end else begin
                pv_q <= pv_d;
                cp_q <= cp_d;
            end
        end

        assign pass_valid = pv_q;
        assign cond_pass  = cp_q;
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = stall ^ flush;
        assign pass_valid = lane_pv;
        assign cond_pass  = lane_cp;
    end

endmodule
